// File: rtl/lf_cmd_rx_pkg.sv
// Shared definitions for the LF command receiver: command codes, major-mode
// values, FSM state encoding and a saturating-increment helper.
package lf_cmd_rx_pkg;

  localparam logic [3:0] FPGA_CMD_SET_CONFREG                = 4'd1;
  localparam logic [3:0] FPGA_CMD_SET_DIVISOR                = 4'd2;
  localparam logic [3:0] FPGA_CMD_SET_EDGE_DETECT_THRESHOLD  = 4'd3;

  localparam logic [2:0] FPGA_MAJOR_MODE_LF_EDGE_DETECT      = 3'd1;
  localparam logic [2:0] FPGA_MAJOR_MODE_OFF                 = 3'd7;

  // Major mode lives in conf_word[8:6]; power up with the FPGA side OFF.
  localparam logic [11:0] CONF_RESET = {3'b000, FPGA_MAJOR_MODE_OFF, 6'b000000};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lf_cmd_rx_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall detection
// against one extra history flop.
module lf_cmd_rx_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic out_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign out_s = sync_q[SYNC_STAGES-1];
  assign rise  = out_s & ~prev_q;
  assign fall  = ~out_s & prev_q;

endmodule

// File: rtl/lf_cmd_rx.sv
// ARM->FPGA SPI command receiver in the pck0 domain: frames are assembled MSB
// first, length-checked on ncs rise, then committed to the config registers.
//
// state     | meaning
// ST_IDLE   | waiting for an ncs falling edge
// ST_SHIFT  | collecting bits on spck rise until ncs rises
// ST_COMMIT | one cycle, new config and cmd_strobe visible
// ST_ERR    | one cycle, frame_err visible, err_cnt bumped
module lf_cmd_rx
  import lf_cmd_rx_pkg::*;
#(
  parameter int         FRAME_BITS    = 16,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] DEF_DIVISOR   = 8'd95,
  parameter logic [7:0] DEF_THRESHOLD = 8'd127
) (
  input  logic        pck0,
  input  logic        nreset,
  input  logic        spck,
  input  logic        mosi,
  input  logic        ncs,
  output logic [11:0] conf_word,
  output logic [7:0]  divisor,
  output logic [7:0]  lf_ed_threshold,
  output logic        cmd_strobe,
  output logic [3:0]  cmd_code,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic spck_rise, ncs_s, ncs_rise, ncs_fall, mosi_s;
  logic unused_spck_s, unused_spck_fall, unused_mosi_rise, unused_mosi_fall;

  lf_cmd_rx_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_spck (
    .clk(pck0), .nreset(nreset), .d(spck),
    .out_s(unused_spck_s), .rise(spck_rise), .fall(unused_spck_fall)
  );

  lf_cmd_rx_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(pck0), .nreset(nreset), .d(mosi),
    .out_s(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  lf_cmd_rx_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(pck0), .nreset(nreset), .d(ncs),
    .out_s(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [11:0]           conf_word_q, conf_word_d;
  logic [7:0]            divisor_q, divisor_d;
  logic [7:0]            threshold_q, threshold_d;
  logic                  cmd_strobe_q, cmd_strobe_d;
  logic [3:0]            cmd_code_q, cmd_code_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    conf_word_d  = conf_word_q;
    divisor_d    = divisor_q;
    threshold_d  = threshold_q;
    cmd_strobe_d = 1'b0;
    cmd_code_d   = cmd_code_q;
    frame_err_d  = 1'b0;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end

      ST_SHIFT: begin
        // ncs rise wins over a coincident spck rise, so that bit is dropped.
        if (ncs_rise) begin
          if (bit_cnt_q == CNT_FULL) begin
            state_d      = ST_COMMIT;
            cmd_strobe_d = 1'b1;
            cmd_code_d   = sr_q[15:12];
            case (sr_q[15:12])
              FPGA_CMD_SET_CONFREG: begin
                conf_word_d = sr_q[11:0];
                if (sr_q[8:6] == FPGA_MAJOR_MODE_LF_EDGE_DETECT)
                  threshold_d = DEF_THRESHOLD;
              end
              FPGA_CMD_SET_DIVISOR:               divisor_d   = sr_q[7:0];
              FPGA_CMD_SET_EDGE_DETECT_THRESHOLD: threshold_d = sr_q[7:0];
              default: ;
            endcase
          end else begin
            state_d     = ST_ERR;
            frame_err_d = 1'b1;
            err_cnt_d   = sat_inc8(err_cnt_q);
          end
        end else if (spck_rise && !ncs_s) begin
          sr_d = {sr_q[FRAME_BITS-2:0], mosi_s};
          if (bit_cnt_q != CNT_MAX)
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      ST_COMMIT: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pck0) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      conf_word_q  <= CONF_RESET;
      divisor_q    <= DEF_DIVISOR;
      threshold_q  <= DEF_THRESHOLD;
      cmd_strobe_q <= 1'b0;
      cmd_code_q   <= 4'd0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      conf_word_q  <= conf_word_d;
      divisor_q    <= divisor_d;
      threshold_q  <= threshold_d;
      cmd_strobe_q <= cmd_strobe_d;
      cmd_code_q   <= cmd_code_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign conf_word       = conf_word_q;
  assign divisor         = divisor_q;
  assign lf_ed_threshold = threshold_q;
  assign cmd_strobe      = cmd_strobe_q;
  assign cmd_code        = cmd_code_q;
  assign frame_err       = frame_err_q;
  assign err_cnt         = err_cnt_q;

endmodule
